// File: rtl/alu_add_seq_pkg.sv
// Shared definitions for the sequential add/subtract unit.
//   - op encodings for ADD/SUB/ADC/SBC
//   - FSM state type
package alu_add_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_add_seq_cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder.
// Ports:
//   a, b      : slice operands
//   ci        : carry into bit 0
//   s         : slice sum
//   c_msb_in  : carry into the slice MSB (for overflow detection)
//   co        : carry out of the slice MSB
module cla_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             c_msb_in,
    output logic             co
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             pa;

    // Each carry is built as a flat sum of generate terms gated by the
    // product of the propagates above them, so no carry depends on another.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        pa   = 1'b0;
        c[0] = ci;
        for (int unsigned i = 0; i < SLICE; i++) begin
            c[i+1] = g[i];
            pa     = p[i];
            for (int j = int'(i) - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pa & g[j]);
                pa     = pa & p[j];
            end
            c[i+1] = c[i+1] | (pa & ci);
        end
    end

    assign s        = p ^ c[SLICE-1:0];
    assign c_msb_in = c[SLICE-1];
    assign co       = c[SLICE];

endmodule

// File: rtl/alu_add_seq.sv
// Multi-cycle add/subtract unit: one SLICE-bit CLA slice per clock.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   start, op, cin, a, b : request (accepted while busy=0), operation, carry-in, operands
//   s                    : result, valid when done pulses, held until next completion
//   c/v/n/z_flag         : carry, signed overflow, negative, zero flags of the result
//   busy, done           : computing / one-cycle completion pulse
module alu_add_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c_flag,
    output logic             v_flag,
    output logic             n_flag,
    output logic             z_flag,
    output logic             busy,
    output logic             done
);
    import alu_add_seq_pkg::*;

    localparam int unsigned NS = WIDTH / SLICE;
    localparam int unsigned CW = $clog2(NS);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             zacc_q;

    logic [WIDTH-1:0] b_in;
    logic             init_c;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sum_sl;
    logic             c_msb;
    logic             co_sl;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-edge control
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    accept  = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(NS - 1)) begin
                    state_d = S_IDLE;
                    last    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand conditioning at the accepting edge: subtraction is a + ~b + 1
    always_comb begin
        b_in   = b;
        init_c = cin;
        case (op)
            OP_ADD:  init_c = 1'b0;
            OP_SUB:  begin b_in = ~b; init_c = 1'b1; end
            OP_ADC:  init_c = cin;
            OP_SBC:  b_in = ~b;
            default: init_c = 1'b0;
        endcase
    end

    // Select the operand slice addressed by the counter
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end
    end

    cla_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_sl),
        .b        (b_sl),
        .ci       (carry_q),
        .s        (sum_sl),
        .c_msb_in (c_msb),
        .co       (co_sl)
    );

    // Datapath, counter, result and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            s       <= '0;
            c_flag  <= 1'b0;
            v_flag  <= 1'b0;
            n_flag  <= 1'b0;
            z_flag  <= 1'b0;
        end else begin
            busy <= (state_d == S_BUSY);
            done <= last;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_in;
                carry_q <= init_c;
                cnt_q   <= '0;
                zacc_q  <= 1'b0;
            end else if (state_q == S_BUSY) begin
                for (int unsigned k = 0; k < NS; k++) begin
                    if (cnt_q == CW'(k)) begin
                        s[k*SLICE +: SLICE] <= sum_sl;
                    end
                end
                carry_q <= co_sl;
                zacc_q  <= zacc_q | (|sum_sl);
                cnt_q   <= last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    c_flag <= co_sl;
                    v_flag <= c_msb ^ co_sl;
                    n_flag <= sum_sl[SLICE-1];
                    z_flag <= ~(zacc_q | (|sum_sl));
                end
            end
        end
    end

endmodule

// File: doc/alu_add_seq.md
# alu_add_seq

Parametrised, multi-cycle add/subtract unit for the ALU datapath. It processes a WIDTH-bit operand pair one SLICE-bit carry-lookahead slice per clock, holding the inter-slice carry in a register. It produces the registered sum/difference plus C, V, N and Z flags, with a start/busy/done handshake. It is the width-generalised, sequential successor to the team's 4-bit CLA with overflow carries, and trades latency for a single small adder slice.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle. NS = WIDTH/SLICE, and NS ≥ 2 is required.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising edge while busy=0.
- op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
- cin  input  1  carry-in for ADC/SBC; ignored for ADD/SUB.
- a, b  input  WIDTH  operands, sampled only on the accepting edge.
- s  output  WIDTH  result; holds its value until the next completion.
- c_flag, v_flag, n_flag, z_flag  output  1 each  carry, signed overflow, negative and zero flags for the result.
- busy  output  1  high while slices are being computed.
- done  output  1  single-cycle pulse when s and the flags become valid.

## Operation
- States: IDLE and BUSY, held in one state register.
  - IDLE→BUSY on an edge with start=1.
  - BUSY→IDLE on the edge that computes slice NS-1.
- Accepting edge:
  - latch a; latch b, inverted for SUB and SBC.
  - load the carry register with the initial carry: ADD 0, SUB 1, ADC cin, SBC cin.
  - clear the slice counter and the zero accumulator.
- Each BUSY edge k, for k = 0..NS-1:
  - add slice k of a and of the conditioned b, with the carry register as carry-in.
  - write the sum into s[k*SLICE +: SLICE].
  - carry register ← slice carry-out.
  - zero accumulator ← accumulator OR (slice sum ≠ 0).
- Final slice (k = NS-1):
  - c_flag ← carry-out of the MSB. For SUB/SBC, 1 means no borrow.
  - v_flag ← carry into the MSB XOR carry out of the MSB.
  - n_flag ← s[WIDTH-1].
  - z_flag ← NOT the final accumulator.
- s is updated slice by slice during BUSY, so its partial contents are not valid until done.
- The flags update only on the final edge; they keep their previous values during BUSY.
- start while busy=1 is ignored. There is no queuing and no error indication.
- Width rules:
  - counter width = $clog2(NS).
  - arithmetic is modulo 2^WIDTH; there is no saturation.
  - a and b are treated as two's complement only for v_flag and n_flag.

## Timing
- Reset (reset_n low, asynchronous, any state):
  - s=0, all flags=0, busy=0, done=0.
  - state=IDLE, counter=0, carry register=0.
  - A computation in progress is discarded and no done is produced.
- Start sampled at edge t:
  - busy=1 after edge t.
  - slices are computed on edges t+1 … t+NS.
  - after edge t+NS: busy=0, done=1, s and flags valid.
  - after edge t+NS+1: done=0.
- Latency is NS cycles from the accepting edge to done; throughput is one operation per NS+1 cycles.
- Back-to-back: start may be held high during the done cycle, since busy=0 then. It is accepted on edge t+NS+1, and done still pulses for exactly one cycle.
- Operands may change freely after the accepting edge.
- Reset release is synchronised externally; the block needs no extra release delay.

## Structure
- Package alu_add_seq_pkg:
  - op encodings OP_ADD, OP_SUB, OP_ADC, OP_SBC.
  - state enum {S_IDLE, S_BUSY}.
- Sub-module cla_slice: combinational SLICE-bit carry-lookahead adder.
  - inputs: a, b, ci.
  - outputs: s, c_msb_in (carry into the MSB), co.
  - One instance only. The top level holds all registers, the FSM, the counter and the flag logic.

## Test plan
- ADD: a=0x7FFFFFFF, b=0x00000001 → done exactly 8 cycles after the accepting edge; s=0x80000000, c=0, v=1, n=1, z=0.
- SUB: a=5, b=5 → s=0, z=1, c=1, v=0, n=0. Then SUB a=0, b=1 → s=0xFFFFFFFF, c=0, v=0, n=1.
- ADC: a=0xFFFFFFFF, b=0, cin=1 → s=0, c=1, z=1. SBC: a=0x80000000, b=0, cin=0 → s=0x7FFFFFFF, v=1, c=1.
- Handshake:
  - start pulsed again at cycle 3 of BUSY → ignored; exactly one done, and the result matches the first operands.
  - start held high continuously → done every 9 cycles, each pulse one cycle wide.
- Reset: assert reset_n=0 mid-BUSY (slice 3) → s, flags, busy and done read 0 immediately. After release, the next start completes normally with the correct result.
- Parameter sweep: WIDTH=16/SLICE=4 and WIDTH=32/SLICE=8 → latency equals NS. Random ADD/SUB/ADC/SBC results and flags match a reference model over 10k operations.
